// File: rtl/pdm_sample_sequencer_pkg.sv
// Shared definitions for the PDM sample sequencer: state encoding, default
// sizes and the pass-length clamp.
package pdm_seq_pkg;

    localparam int unsigned PDM_BUFFER_WIDTH_DEFAULT        = 128;
    localparam int unsigned PDM_BUFFER_ADRESS_WIDTH_DEFAULT = 7;
    localparam int unsigned DIVIDER_WIDTH_DEFAULT           = 16;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_READY = 2'd1,
        ST_RUN        = 2'd2,
        ST_DONE       = 2'd3
    } pdm_seq_state_t;

    // A final address beyond the buffer would select words that do not exist.
    function automatic int unsigned clamp_last_index(input int unsigned idx,
                                                     input int unsigned depth);
        return (idx >= depth) ? depth - 1 : idx;
    endfunction

endpackage

// File: rtl/pdm_sample_sequencer_step_divider.sv
// Clocks-per-sample counter: holds a loaded terminal value, counts up to it
// and wraps to zero, flagging the terminal cycle.
module pdm_step_divider #(
    parameter int unsigned DIVIDER_WIDTH = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     load,
    input  logic [DIVIDER_WIDTH-1:0] load_value,
    input  logic                     clear,
    input  logic                     count_en,
    output logic                     terminal
);

    logic [DIVIDER_WIDTH-1:0] divider;
    logic [DIVIDER_WIDTH-1:0] count;

    assign terminal = (count == divider);

    // Terminal value is configuration data and is always loaded before use.
    always_ff @(posedge aclk) begin
        if (load) begin
            divider <= load_value;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= terminal ? '0 : count + DIVIDER_WIDTH'(1);
        end
    end

endmodule

// File: rtl/pdm_sample_sequencer.sv
// Steps the PDM multiplexer select through the sample buffer at a programmable
// rate, with a done/ack handshake to the buffer loader and optional looping.
module pdm_sample_sequencer
    import pdm_seq_pkg::*;
#(
    parameter int unsigned PDM_BUFFER_WIDTH        = PDM_BUFFER_WIDTH_DEFAULT,
    parameter int unsigned PDM_BUFFER_ADRESS_WIDTH = PDM_BUFFER_ADRESS_WIDTH_DEFAULT,
    parameter int unsigned DIVIDER_WIDTH           = DIVIDER_WIDTH_DEFAULT
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic                               enable,
    input  logic [DIVIDER_WIDTH-1:0]           step_divider,
    input  logic [PDM_BUFFER_ADRESS_WIDTH-1:0] last_index,
    input  logic                               loop_mode,
    input  logic                               buffer_ready,
    input  logic                               buffer_ack,
    output logic [PDM_BUFFER_ADRESS_WIDTH-1:0] sample_select,
    output logic                               sample_strobe,
    output logic                               wrap_pulse,
    output logic                               buffer_done,
    output logic                               running,
    output logic                               underrun
);

    localparam int unsigned AW = PDM_BUFFER_ADRESS_WIDTH;

    pdm_seq_state_t state;
    logic [AW-1:0]  last_q;
    logic           loop_q;
    logic           load_cfg;
    logic           step_now;

    assign load_cfg = (state == ST_IDLE) && enable;

    pdm_step_divider #(
        .DIVIDER_WIDTH (DIVIDER_WIDTH)
    ) u_divider (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .load       (load_cfg),
        .load_value (step_divider),
        .clear      (!enable || (state != ST_RUN)),
        .count_en   (state == ST_RUN),
        .terminal   (step_now)
    );

    // Configuration is captured only on IDLE exit so a pass never sees it change.
    always_ff @(posedge aclk) begin
        if (load_cfg) begin
            last_q <= AW'(clamp_last_index(32'(last_index), PDM_BUFFER_WIDTH));
            loop_q <= loop_mode;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= ST_IDLE;
            sample_select <= '0;
            sample_strobe <= 1'b0;
            wrap_pulse    <= 1'b0;
            buffer_done   <= 1'b0;
            running       <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            sample_strobe <= 1'b0;
            wrap_pulse    <= 1'b0;
            if (!enable) begin
                state         <= ST_IDLE;
                sample_select <= '0;
                buffer_done   <= 1'b0;
                running       <= 1'b0;
                underrun      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state         <= ST_WAIT_READY;
                        sample_select <= '0;
                        underrun      <= 1'b0;
                    end
                    ST_WAIT_READY: begin
                        if (buffer_ready) begin
                            state         <= ST_RUN;
                            sample_select <= '0;
                            sample_strobe <= 1'b1;
                            running       <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (step_now) begin
                            if (sample_select < last_q) begin
                                sample_select <= sample_select + AW'(1);
                                sample_strobe <= 1'b1;
                            end else if (loop_q) begin
                                // Wrapping onto a buffer the loader has not refilled.
                                sample_select <= '0;
                                sample_strobe <= 1'b1;
                                wrap_pulse    <= 1'b1;
                                if (!buffer_ready) begin
                                    underrun <= 1'b1;
                                end
                            end else begin
                                state       <= ST_DONE;
                                running     <= 1'b0;
                                buffer_done <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (buffer_ack) begin
                            state       <= ST_WAIT_READY;
                            buffer_done <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pdm_sample_sequencer.sv
// Self-checking bench for pdm_sample_sequencer (buffer depth 100, 7-bit address).
module tb_pdm_sample_sequencer;

    localparam int BUF_W = 100;
    localparam int AW    = 7;
    localparam int DW    = 16;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          enable;
    logic [DW-1:0] step_divider;
    logic [AW-1:0] last_index;
    logic          loop_mode;
    logic          buffer_ready;
    logic          buffer_ack;
    logic [AW-1:0] sample_select;
    logic          sample_strobe;
    logic          wrap_pulse;
    logic          buffer_done;
    logic          running;
    logic          underrun;

    int checks = 0;
    int passes = 0;

    pdm_sample_sequencer #(
        .PDM_BUFFER_WIDTH        (BUF_W),
        .PDM_BUFFER_ADRESS_WIDTH (AW),
        .DIVIDER_WIDTH           (DW)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .enable        (enable),
        .step_divider  (step_divider),
        .last_index    (last_index),
        .loop_mode     (loop_mode),
        .buffer_ready  (buffer_ready),
        .buffer_ack    (buffer_ack),
        .sample_select (sample_select),
        .sample_strobe (sample_strobe),
        .wrap_pulse    (wrap_pulse),
        .buffer_done   (buffer_done),
        .running       (running),
        .underrun      (underrun)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic          en;
        logic          rdy;
        logic          ack;
        logic [AW-1:0] sel;
        logic          str;
        logic          wr;
        logic          dn;
        logic          rn;
        logic          und;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mkv(int en, int rdy, int ack, int sel,
                                 int str, int wr, int dn, int rn, int und);
        vec_t v;
        v.en  = (en != 0);
        v.rdy = (rdy != 0);
        v.ack = (ack != 0);
        v.sel = AW'(sel);
        v.str = (str != 0);
        v.wr  = (wr != 0);
        v.dn  = (dn != 0);
        v.rn  = (rn != 0);
        v.und = (und != 0);
        return v;
    endfunction

    function automatic logic [11:0] outs();
        return {sample_select, sample_strobe, wrap_pulse, buffer_done, running, underrun};
    endfunction

    // Expected outputs n cycles after entering RUN with ready held high and no ack.
    function automatic logic [11:0] model(int n, int s, int l, bit lp);
        int  p;
        int  lc;
        int  addr;
        bit  stb;
        bit  wr;
        bit  dn;
        bit  rn;
        p   = s + 1;
        lc  = (l >= BUF_W) ? BUF_W - 1 : l;
        stb = 1'b0;
        wr  = 1'b0;
        dn  = 1'b0;
        rn  = 1'b1;
        if (lp || n < (lc + 1) * p) begin
            addr = (n / p) % (lc + 1);
            stb  = (n % p == 0);
            wr   = lp && stb && (addr == 0) && (n > 0);
        end else begin
            addr = lc;
            dn   = 1'b1;
            rn   = 1'b0;
        end
        return {AW'(addr), stb, wr, dn, rn, 1'b0};
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got == want) passes++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int  strobes;
        int  cycles;
        bit  found;
        int  s;
        int  l;
        bit  lp;
        int  ncyc;

        aresetn      = 1'b0;
        enable       = 1'b0;
        step_divider = '0;
        last_index   = '0;
        loop_mode    = 1'b0;
        buffer_ready = 1'b0;
        buffer_ack   = 1'b0;

        vecs[0]  = mkv(1, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mkv(1, 1, 0, 0, 1, 0, 0, 1, 0);
        vecs[2]  = mkv(1, 1, 0, 1, 1, 0, 0, 1, 0);
        vecs[3]  = mkv(1, 1, 0, 2, 1, 0, 0, 1, 0);
        vecs[4]  = mkv(1, 1, 0, 0, 1, 1, 0, 1, 0);
        vecs[5]  = mkv(1, 1, 0, 1, 1, 0, 0, 1, 0);
        vecs[6]  = mkv(1, 1, 0, 2, 1, 0, 0, 1, 0);
        vecs[7]  = mkv(1, 1, 0, 0, 1, 1, 0, 1, 0);
        vecs[8]  = mkv(1, 0, 0, 1, 1, 0, 0, 1, 0);
        vecs[9]  = mkv(1, 0, 0, 2, 1, 0, 0, 1, 0);
        vecs[10] = mkv(1, 0, 0, 0, 1, 1, 0, 1, 1);
        vecs[11] = mkv(1, 1, 0, 1, 1, 0, 0, 1, 1);
        vecs[12] = mkv(1, 1, 0, 2, 1, 0, 0, 1, 1);
        vecs[13] = mkv(0, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[14] = mkv(0, 1, 0, 0, 0, 0, 0, 0, 0);

        #12;
        check("reset_outputs", int'(outs()), 0);
        aresetn = 1'b1;
        step();
        check("idle_after_reset", int'(outs()), 0);

        // Basic playback.
        step_divider = 16'd3;
        last_index   = 7'd4;
        loop_mode    = 1'b0;
        buffer_ready = 1'b1;
        enable       = 1'b1;
        step();
        check("play_wait_running", int'(running), 0);
        step();
        strobes = 0;
        for (int n = 0; n < 20; n++) begin
            check("play_sel", int'(sample_select), n / 4);
            check("play_stb", int'(sample_strobe), (n % 4 == 0) ? 1 : 0);
            if (sample_strobe) strobes++;
            step();
        end
        check("play_strobe_count", strobes, 5);
        check("play_done_entry", int'(outs()), int'({7'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}));
        step();
        check("play_done_hold", int'(buffer_done), 1);
        buffer_ack = 1'b1;
        step();
        buffer_ack = 1'b0;
        check("play_ack_clears", int'(buffer_done), 0);
        step();
        check("play_next_pass", int'(outs()), int'({7'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}));
        enable = 1'b0;
        step();

        // Looping and underrun vectors.
        step_divider = 16'd0;
        last_index   = 7'd2;
        loop_mode    = 1'b1;
        for (int i = 0; i < 15; i++) begin
            enable       = vecs[i].en;
            buffer_ready = vecs[i].rdy;
            buffer_ack   = vecs[i].ack;
            step();
            check($sformatf("vec%0d", i), int'(outs()),
                  int'({vecs[i].sel, vecs[i].str, vecs[i].wr, vecs[i].dn, vecs[i].rn, vecs[i].und}));
        end

        // Abort mid-pass, then a divider change made in IDLE.
        step_divider = 16'd1;
        last_index   = 7'd9;
        loop_mode    = 1'b0;
        buffer_ready = 1'b1;
        enable       = 1'b1;
        step();
        step();
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (sample_select == 7'd5) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("abort_reached_5", int'(found), 1);
        enable = 1'b0;
        step();
        check("abort_idle", int'(outs()), 0);
        step_divider = 16'd0;
        enable       = 1'b1;
        step();
        step();
        check("reen_first", int'(outs()), int'({7'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}));
        step_divider = 16'd7;
        last_index   = 7'd0;
        step();
        check("reen_fast_step", int'(outs()), int'({7'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}));
        step();
        check("reen_cfg_ignored", int'(sample_select), 2);
        enable = 1'b0;
        step();

        // Clamp: last_index beyond the buffer ends the pass at 99.
        step_divider = 16'd0;
        last_index   = 7'd127;
        loop_mode    = 1'b0;
        enable       = 1'b1;
        step();
        step();
        strobes = 0;
        cycles  = 0;
        found   = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (buffer_done) begin
                found  = 1'b1;
                cycles = i;
                break;
            end
            if (sample_strobe) strobes++;
            step();
        end
        check("clamp_done_seen", int'(found), 1);
        check("clamp_strobes", strobes, 100);
        check("clamp_cycles", cycles, 100);
        check("clamp_final_sel", int'(sample_select), 99);
        enable = 1'b0;
        step();

        // Single-address pass with ack already high on DONE entry.
        step_divider = 16'd2;
        last_index   = 7'd0;
        buffer_ack   = 1'b1;
        enable       = 1'b1;
        step();
        step();
        check("single_strobe", int'(outs()), int'({7'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}));
        step();
        check("single_hold", int'(sample_strobe), 0);
        step();
        step();
        check("single_done", int'(outs()), int'({7'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}));
        step();
        check("single_early_ack", int'(buffer_done), 0);
        enable     = 1'b0;
        buffer_ack = 1'b0;
        step();

        // Asynchronous reset mid-RUN.
        step_divider = 16'd2;
        last_index   = 7'd5;
        loop_mode    = 1'b1;
        enable       = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("areset_pre_running", int'(running), 1);
        aresetn = 1'b0;
        #1;
        check("areset_immediate", int'(outs()), 0);
        enable = 1'b0;
        #1;
        aresetn = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("areset_stays_idle", int'(outs()), 0);
        enable = 1'b1;
        step();
        check("areset_wait", int'({sample_strobe, running}), 0);
        step();
        check("areset_restart", int'({sample_strobe, running}), 3);
        enable = 1'b0;
        step();

        // Randomised passes against the arithmetic model.
        for (int it = 0; it < 12; it++) begin
            s  = $urandom_range(0, 4);
            lp = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) begin
                l = $urandom_range(100, 127);
                s = 0;
            end else begin
                l = $urandom_range(0, 12);
            end
            step_divider = DW'(s);
            last_index   = AW'(l);
            loop_mode    = lp;
            buffer_ready = 1'b1;
            buffer_ack   = 1'b0;
            enable       = 1'b1;
            step();
            step();
            ncyc = ((l >= BUF_W) ? BUF_W : l + 1) * (s + 1);
            ncyc = lp ? 2 * ncyc + 3 : ncyc + 3;
            for (int n = 0; n < ncyc; n++) begin
                check($sformatf("rand%0d_n%0d", it, n), int'(outs()), int'(model(n, s, l, lp)));
                step_divider = DW'($urandom_range(0, 9));
                last_index   = AW'($urandom_range(0, 127));
                loop_mode    = 1'($urandom_range(0, 1));
                step();
            end
            enable = 1'b0;
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pdm_sample_sequencer.md
Name: pdm_sample_sequencer

Overview:
- Sequences the PDM sample multiplexer.
- Steps the sample-select address through a buffer of up to PDM_BUFFER_WIDTH PDM words at a programmable rate.
- Handshakes with the buffer loader (done/ack) so new buffer content can be swapped in between passes; optional looping over the same buffer.
- Sits between the PS-side configuration registers and the multiplexer select input.

Parameters:
- PDM_BUFFER_WIDTH, 128, number of PDM words in the buffer.
- PDM_BUFFER_ADRESS_WIDTH, 7, width of sample_select; must satisfy 2**W >= PDM_BUFFER_WIDTH.
- DIVIDER_WIDTH, 16, width of the clocks-per-sample divider.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- enable  in  1  level; high runs the sequencer, low forces IDLE.
- step_divider  in  DIVIDER_WIDTH  clocks per sample minus 1; latched on leaving IDLE.
- last_index  in  PDM_BUFFER_ADRESS_WIDTH  final address of a pass; latched on leaving IDLE.
- loop_mode  in  1  1 = wrap to 0 after last_index; 0 = stop in DONE; latched on leaving IDLE.
- buffer_ready  in  1  level from loader; buffer content valid.
- buffer_ack  in  1  loader acknowledge of buffer_done.
- sample_select  out  PDM_BUFFER_ADRESS_WIDTH  address to the multiplexer.
- sample_strobe  out  1  one-cycle pulse whenever sample_select takes a new value in RUN.
- wrap_pulse  out  1  one-cycle pulse on wrap to 0 in loop mode.
- buffer_done  out  1  high in DONE until acked.
- running  out  1  high in RUN.
- underrun  out  1  sticky error flag.

Behaviour:
- Reset values: all outputs 0; state IDLE; divider counter 0.
- States are IDLE, WAIT_READY, RUN, DONE.
- IDLE:
  - sample_select is 0.
  - enable=1 → WAIT_READY next cycle; config inputs are latched on that edge.
  - last_index >= PDM_BUFFER_WIDTH is latched as PDM_BUFFER_WIDTH-1.
- WAIT_READY: buffer_ready=1 → RUN next cycle, with sample_select=0, counter=0, sample_strobe=1 in the first RUN cycle.
- RUN:
  - The counter increments each cycle.
  - When counter==step_divider: counter←0, and the next cycle behaves as follows:
    - If sample_select<last_index: sample_select+1, sample_strobe=1.
    - Else if loop_mode=1: sample_select←0, sample_strobe=1, wrap_pulse=1. If buffer_ready=0 at this instant, underrun←1 and playback continues anyway.
    - Else: → DONE, sample_select holds last_index, no strobe.
  - step_divider=0 steps every cycle; each address is held for exactly step_divider+1 cycles.
- DONE:
  - buffer_done=1.
  - buffer_ack=1 sampled → buffer_done cleared next cycle; → WAIT_READY.
  - buffer_ack already high on DONE entry counts as ack after one cycle in DONE.
- enable=0 in any state → IDLE next cycle, with sample_select←0 and counter←0. buffer_done, running and pending strobes are cleared.
- underrun is cleared only in IDLE or by reset.
- last_index=0: every pass is a single address. Loop mode strobes address 0 every step_divider+1 cycles with wrap_pulse each time.
- Counter arithmetic is unsigned and never exceeds step_divider; there is no overflow.
- Config changes while not in IDLE are ignored until the next IDLE exit.
- Reset asserted mid-operation: immediate return to reset values; no handshake completion is owed to the loader.

Decomposition:
- Package pdm_seq_pkg holds:
  - the state encoding (IDLE=0, WAIT_READY=1, RUN=2, DONE=3);
  - default parameter constants;
  - the last_index clamp function.
- One sub-module, pdm_step_divider: counter with load/clear and a terminal-count output. It is parameterised by DIVIDER_WIDTH.
- The FSM and address logic stay in the top module.

Test Plan:
1. Basic playback: reset, step_divider=3, last_index=4, loop_mode=0, enable=1, buffer_ready=1.
   - sample_select runs 0,1,2,3,4, each held 4 cycles, with 5 strobes.
   - Then DONE with buffer_done=1 and sample_select=4.
   - buffer_ack pulse → buffer_done=0 next cycle.
2. Loop: step_divider=0, last_index=2, loop_mode=1.
   - sample_select cycles 0,1,2,0,1,2 on consecutive cycles.
   - wrap_pulse every 3rd cycle coincides with select=0; underrun stays 0.
3. Underrun: loop mode as in 2, buffer_ready dropped mid-pass.
   - At the next wrap, underrun=1 and playback continues.
   - underrun stays 1 until enable=0, then clears in IDLE.
4. Abort: enable dropped while sample_select=5 in RUN.
   - Next cycle: IDLE, sample_select=0, running=0, no strobe.
   - A step_divider change made in IDLE takes effect on re-enable.
5. Clamp and edge: last_index=127 with PDM_BUFFER_WIDTH=100.
   - Pass ends at 99.
   - last_index=0, loop_mode=0: one strobe at address 0, then DONE.
6. Async reset asserted mid-RUN.
   - All outputs 0 immediately, without waiting for an aclk edge.
   - After release, stays IDLE until enable=1.
